// File: rtl/bus_read_arbiter_pkg.sv
// Shared IDs and widths for the instruction/data read arbiter.
package bus_read_arbiter_pkg;
  localparam int BUS_WIDTH       = 32;
  localparam int RD_ARB_ID_WIDTH = 1;

  typedef enum logic [RD_ARB_ID_WIDTH-1:0] {
    RD_ARB_ID_INST = 1'b0,
    RD_ARB_ID_DATA = 1'b1
  } rd_arb_id_t;

  function automatic rd_arb_id_t other_id(input rd_arb_id_t id);
    return (id == RD_ARB_ID_INST) ? RD_ARB_ID_DATA : RD_ARB_ID_INST;
  endfunction
endpackage

// File: rtl/bus_read_arbiter_id_fifo.sv
// In-order ID FIFO for reads in flight; head is combinational, push/pop take effect next cycle.
// Caller must not push when full nor pop when empty.
module rd_arb_id_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 1,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
      end
      if (pop)
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
      if (push && !pop)
        count <= count + CW'(1);
      else if (pop && !push)
        count <= count - CW'(1);
    end
  end
endmodule

// File: rtl/bus_read_arbiter.sv
// Arbitrates ir/dr reads onto one memory channel; 0-cycle comb address and data paths, returns routed in order.
// Backpressure: grant locks until mem_addr_ready; no grant when full; data stalls on the head requester's ready. Round-robin with BUS_READ_ARB_ROUND_ROBIN_EN.
module bus_read_arbiter
  import bus_read_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               ir_addr_valid,
  output logic                               ir_addr_ready,
  input  logic [BUS_WIDTH-1:0]               ir_addr,
  output logic                               ir_data_valid,
  input  logic                               ir_data_ready,
  output logic [BUS_WIDTH-1:0]               ir_data,
  input  logic                               dr_addr_valid,
  output logic                               dr_addr_ready,
  input  logic [BUS_WIDTH-1:0]               dr_addr,
  output logic                               dr_data_valid,
  input  logic                               dr_data_ready,
  output logic [BUS_WIDTH-1:0]               dr_data,
  output logic                               mem_addr_valid,
  input  logic                               mem_addr_ready,
  output logic [BUS_WIDTH-1:0]               mem_addr,
  input  logic                               mem_data_valid,
  output logic                               mem_data_ready,
  input  logic [BUS_WIDTH-1:0]               mem_data,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding
);
  logic                       grant_vld;
  rd_arb_id_t                 grant_id;
  logic                       lock;
  rd_arb_id_t                 locked_id;
  logic                       push;
  logic                       pop;
  logic                       full;
  logic                       empty;
  logic [RD_ARB_ID_WIDTH-1:0] head_raw;
  rd_arb_id_t                 head;

`ifdef BUS_READ_ARB_ROUND_ROBIN_EN
  rd_arb_id_t rr_ptr;

  always_ff @(posedge clk) begin
    if (!rst)
      rr_ptr <= RD_ARB_ID_INST;
    else if (push)
      rr_ptr <= other_id(grant_id);
  end
`endif

  always_comb begin
    grant_vld = 1'b0;
    grant_id  = RD_ARB_ID_INST;
    if (rst && !full) begin
      if (lock) begin
        // Hold the stalled grant so the presented request is never dropped.
        grant_id  = locked_id;
        grant_vld = (locked_id == RD_ARB_ID_DATA) ? dr_addr_valid : ir_addr_valid;
      end else begin
`ifdef BUS_READ_ARB_ROUND_ROBIN_EN
        if (ir_addr_valid && dr_addr_valid) begin
          grant_vld = 1'b1;
          grant_id  = rr_ptr;
        end else if (dr_addr_valid) begin
          grant_vld = 1'b1;
          grant_id  = RD_ARB_ID_DATA;
        end else if (ir_addr_valid) begin
          grant_vld = 1'b1;
          grant_id  = RD_ARB_ID_INST;
        end
`else
        if (dr_addr_valid) begin
          grant_vld = 1'b1;
          grant_id  = RD_ARB_ID_DATA;
        end else if (ir_addr_valid) begin
          grant_vld = 1'b1;
          grant_id  = RD_ARB_ID_INST;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      lock      <= 1'b0;
      locked_id <= RD_ARB_ID_INST;
    end else if (push) begin
      lock      <= 1'b0;
    end else if (grant_vld) begin
      lock      <= 1'b1;
      locked_id <= grant_id;
    end
  end

  assign mem_addr_valid = grant_vld;
  assign mem_addr       = (grant_id == RD_ARB_ID_DATA) ? dr_addr : ir_addr;
  assign ir_addr_ready  = grant_vld && (grant_id == RD_ARB_ID_INST) && mem_addr_ready;
  assign dr_addr_ready  = grant_vld && (grant_id == RD_ARB_ID_DATA) && mem_addr_ready;
  assign push           = grant_vld && mem_addr_ready;

  assign head           = rd_arb_id_t'(head_raw);
  assign ir_data        = mem_data;
  assign dr_data        = mem_data;
  assign ir_data_valid  = rst && !empty && (head == RD_ARB_ID_INST) && mem_data_valid;
  assign dr_data_valid  = rst && !empty && (head == RD_ARB_ID_DATA) && mem_data_valid;
  assign mem_data_ready = rst && !empty &&
                          ((head == RD_ARB_ID_INST) ? ir_data_ready : dr_data_ready);
  assign pop            = mem_data_valid && mem_data_ready;

  rd_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (RD_ARB_ID_WIDTH)
  ) u_id_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (grant_id),
    .pop   (pop),
    .dout  (head_raw),
    .full  (full),
    .empty (empty),
    .count (outstanding)
  );
endmodule

// File: tb/tb_bus_read_arbiter.sv
// Directed table-driven bench for bus_read_arbiter (MAX_OUTSTANDING=2), both arbitration builds.
module tb_bus_read_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        ir_addr_valid, ir_addr_ready, ir_data_valid, ir_data_ready;
  logic        dr_addr_valid, dr_addr_ready, dr_data_valid, dr_data_ready;
  logic        mem_addr_valid, mem_addr_ready, mem_data_valid, mem_data_ready;
  logic [31:0] ir_addr, ir_data, dr_addr, dr_data, mem_addr, mem_data;
  logic [1:0]  outstanding;

  int n_cmp = 0;
  int n_bad = 0;

  bus_read_arbiter #(.MAX_OUTSTANDING(2)) dut (
    .clk(clk), .rst(rst),
    .ir_addr_valid(ir_addr_valid), .ir_addr_ready(ir_addr_ready), .ir_addr(ir_addr),
    .ir_data_valid(ir_data_valid), .ir_data_ready(ir_data_ready), .ir_data(ir_data),
    .dr_addr_valid(dr_addr_valid), .dr_addr_ready(dr_addr_ready), .dr_addr(dr_addr),
    .dr_data_valid(dr_data_valid), .dr_data_ready(dr_data_ready), .dr_data(dr_data),
    .mem_addr_valid(mem_addr_valid), .mem_addr_ready(mem_addr_ready), .mem_addr(mem_addr),
    .mem_data_valid(mem_data_valid), .mem_data_ready(mem_data_ready), .mem_data(mem_data),
    .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv, dv, mar, mdv, ird, drd;
    logic [31:0] mdat;
    logic        e_mav;
    logic [31:0] e_maddr;
    logic        e_iar, e_dar, e_idv, e_ddv, e_mdr;
    logic [1:0]  e_out;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic dv, input logic mar,
                       input logic mdv, input logic ird, input logic drd,
                       input logic [31:0] mdat);
    ir_addr_valid  = iv;
    dr_addr_valid  = dv;
    mem_addr_ready = mar;
    mem_data_valid = mdv;
    ir_data_ready  = ird;
    dr_data_ready  = drd;
    mem_data       = mdat;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_addr(input string tag, input logic mav, input logic [31:0] maddr,
                          input logic iar, input logic dar);
    chk({tag, " mem_addr_valid"}, {31'b0, mem_addr_valid}, {31'b0, mav});
    if (mav) chk({tag, " mem_addr"}, mem_addr, maddr);
    chk({tag, " ir_addr_ready"}, {31'b0, ir_addr_ready}, {31'b0, iar});
    chk({tag, " dr_addr_ready"}, {31'b0, dr_addr_ready}, {31'b0, dar});
  endtask

  initial begin
    ir_addr = 32'h100;
    dr_addr = 32'h200;
    rst     = 1'b0;
    drive(1, 1, 1, 1, 1, 1, 32'h1234);

    // Reset: requests and memory activity present, everything held quiet.
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_addr("reset", 1'b0, 32'h0, 1'b0, 1'b0);
      chk("reset ir_data_valid", {31'b0, ir_data_valid}, 32'h0);
      chk("reset dr_data_valid", {31'b0, dr_data_valid}, 32'h0);
      chk("reset mem_data_ready", {31'b0, mem_data_ready}, 32'h0);
      chk("reset outstanding", {30'b0, outstanding}, 32'h0);
    end
    rst = 1'b1;
    drive(1, 0, 0, 0, 0, 0, 32'h0);
    #1;
    chk_addr("post-reset grant", 1'b1, 32'h100, 1'b0, 1'b0);
    drive(0, 0, 0, 0, 0, 0, 32'h0);
    tick();

    // Cycle-by-cycle table: simultaneous requests, single ir read, stray data, ir data stall.
`ifdef BUS_READ_ARB_ROUND_ROBIN_EN
    vecs[0] = '{1,1,1,0,0,0,32'h0,          1,32'h100,1,0,0,0,0,2'd0};
    vecs[1] = '{0,1,1,0,0,0,32'h0,          1,32'h200,0,1,0,0,0,2'd1};
    vecs[2] = '{0,0,0,1,1,1,32'hA1,         0,32'h0,  0,0,1,0,1,2'd2};
    vecs[3] = '{0,0,0,1,1,1,32'hB2,         0,32'h0,  0,0,0,1,1,2'd1};
`else
    vecs[0] = '{1,1,1,0,0,0,32'h0,          1,32'h200,0,1,0,0,0,2'd0};
    vecs[1] = '{1,0,1,0,0,0,32'h0,          1,32'h100,1,0,0,0,0,2'd1};
    vecs[2] = '{0,0,0,1,1,1,32'hA1,         0,32'h0,  0,0,0,1,1,2'd2};
    vecs[3] = '{0,0,0,1,1,1,32'hB2,         0,32'h0,  0,0,1,0,1,2'd1};
`endif
    vecs[4]  = '{1,0,1,0,0,0,32'h0,         1,32'h100,1,0,0,0,0,2'd0};
    vecs[5]  = '{0,0,0,0,1,1,32'h0,         0,32'h0,  0,0,0,0,1,2'd1};
    vecs[6]  = '{0,0,0,1,1,1,32'hDEADBEEF,  0,32'h0,  0,0,1,0,1,2'd1};
    vecs[7]  = '{0,0,0,1,1,1,32'h5555,      0,32'h0,  0,0,0,0,0,2'd0};
    vecs[8]  = '{1,0,1,0,0,0,32'h0,         1,32'h100,1,0,0,0,0,2'd0};
    vecs[9]  = '{0,0,0,1,0,1,32'hC3,        0,32'h0,  0,0,1,0,0,2'd1};
    vecs[10] = '{0,0,0,1,0,1,32'hC3,        0,32'h0,  0,0,1,0,0,2'd1};
    vecs[11] = '{0,0,0,1,1,1,32'hC3,        0,32'h0,  0,0,1,0,1,2'd1};
    vecs[12] = '{0,0,0,0,0,0,32'h0,         0,32'h0,  0,0,0,0,0,2'd0};

    for (int i = 0; i < 13; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive(vecs[i].iv, vecs[i].dv, vecs[i].mar, vecs[i].mdv, vecs[i].ird, vecs[i].drd, vecs[i].mdat);
      #1;
      chk_addr(tag, vecs[i].e_mav, vecs[i].e_maddr, vecs[i].e_iar, vecs[i].e_dar);
      chk({tag, " ir_data_valid"}, {31'b0, ir_data_valid}, {31'b0, vecs[i].e_idv});
      chk({tag, " dr_data_valid"}, {31'b0, dr_data_valid}, {31'b0, vecs[i].e_ddv});
      chk({tag, " mem_data_ready"}, {31'b0, mem_data_ready}, {31'b0, vecs[i].e_mdr});
      chk({tag, " outstanding"}, {30'b0, outstanding}, {30'b0, vecs[i].e_out});
      if (vecs[i].e_idv) chk({tag, " ir_data"}, ir_data, vecs[i].mdat);
      if (vecs[i].e_ddv) chk({tag, " dr_data"}, dr_data, vecs[i].mdat);
      tick();
    end

    // Lock: dr stalled by memory for 4 cycles, ir arrives meanwhile.
    drive(0, 1, 0, 0, 1, 1, 32'h0);
    for (int c = 0; c < 4; c++) begin
      #1;
      chk_addr($sformatf("lock c%0d", c), 1'b1, 32'h200, 1'b0, 1'b0);
      tick();
      ir_addr_valid = 1'b1;
    end
    mem_addr_ready = 1'b1;
    #1;
    chk_addr("lock release", 1'b1, 32'h200, 1'b0, 1'b1);
    tick();
    dr_addr_valid = 1'b0;
    #1;
    chk_addr("after lock ir", 1'b1, 32'h100, 1'b1, 1'b0);
    chk("after lock outstanding", {30'b0, outstanding}, 32'd1);
    tick();

    // Full: no grant, not even while a pop happens in the same cycle.
    drive(0, 1, 1, 0, 1, 1, 32'h0);
    #1;
    chk("full outstanding", {30'b0, outstanding}, 32'd2);
    chk_addr("full stall", 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    mem_data_valid = 1'b1;
    mem_data       = 32'hD1;
    #1;
    chk_addr("full pop no bypass", 1'b0, 32'h0, 1'b0, 1'b0);
    chk("full pop dr_data_valid", {31'b0, dr_data_valid}, 32'h1);
    chk("full pop dr_data", dr_data, 32'hD1);
    tick();
    mem_data_valid = 1'b0;
    #1;
    chk("after pop outstanding", {30'b0, outstanding}, 32'd1);
    chk_addr("after pop grant", 1'b1, 32'h200, 1'b0, 1'b1);
    tick();
    dr_addr_valid  = 1'b0;
    mem_data_valid = 1'b1;
    mem_data       = 32'hE2;
    #1;
    chk("drain ir_data_valid", {31'b0, ir_data_valid}, 32'h1);
    chk("drain ir_data", ir_data, 32'hE2);
    chk("drain dr_data_valid", {31'b0, dr_data_valid}, 32'h0);
    tick();
    mem_data = 32'hF3;
    #1;
    chk("drain2 dr_data_valid", {31'b0, dr_data_valid}, 32'h1);
    chk("drain2 ir_data_valid", {31'b0, ir_data_valid}, 32'h0);
    tick();
    mem_data_valid = 1'b0;
    #1;
    chk("final outstanding", {30'b0, outstanding}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
